axi_req_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single request/response port of the AXI master among NUM_REQ requesters.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/arb_tag_fifo.sv | 52 +++++
 rtl/axi_req_arbiter.sv | 118 +++++++++++
 tb/tb_axi_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and default sizing for the AXI request arbiter.
// The module parameters default to the values below.
package axi_arb_pkg;

   localparam int DEF_NUM_REQ         = 4;
   localparam int DEF_ADDR_W          = 32;
   localparam int DEF_DATA_W          = 32;
   localparam int DEF_MAX_OUTSTANDING = 4;

   localparam int TAG_W = $clog2(DEF_NUM_REQ);
   localparam int CNT_W = $clog2(DEF_MAX_OUTSTANDING) + 1;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]   addr;
      logic [DEF_DATA_W-1:0]   wdata;
      logic                    we;
      logic [DEF_DATA_W/8-1:0] be;
   } req_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding request.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module arb_tag_fifo
   import axi_arb_pkg::*;
#(
   parameter int W     = TAG_W,
   parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // NOTE: storage is left unreset; only the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

   // NOTE: non-blocking assignments keep every register update ordered on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign dout  = mem[rd_ptr[PW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing one AXI master request/response port among NUM_REQ requesters;
// responses return in order and are steered back to the issuer through a tag FIFO.
module axi_req_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ         = DEF_NUM_REQ,
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            s_req_valid,
   output logic [NUM_REQ-1:0]            s_req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]     s_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     s_req_wdata,
   input  logic [NUM_REQ-1:0]            s_req_we,
   input  logic [NUM_REQ*DATA_W/8-1:0]   s_req_be,
   output logic [NUM_REQ-1:0]            s_resp_valid,
   output logic [DATA_W-1:0]             s_resp_rdata,
   output logic                          m_req_valid,
   input  logic                          m_req_ready,
   output logic [ADDR_W-1:0]             m_req_addr,
   output logic [DATA_W-1:0]             m_req_wdata,
   output logic                          m_req_we,
   output logic [DATA_W/8-1:0]           m_req_be,
   input  logic                          m_resp_valid,
   input  logic [DATA_W-1:0]             m_resp_rdata,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic                          err_unexp
);

   localparam int TAG_BITS = $clog2(NUM_REQ);
   localparam int BE_W     = DATA_W / 8;

   logic [TAG_BITS-1:0] rr_ptr;
   logic [TAG_BITS-1:0] lock_idx;
   logic                lock;
   logic [TAG_BITS-1:0] arb_idx;
   logic [TAG_BITS-1:0] grant;
   logic [TAG_BITS-1:0] head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                hs;
   logic                pop;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      arb_idx = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (s_req_valid[(int'(rr_ptr) + k) % NUM_REQ])
            arb_idx = TAG_BITS'((int'(rr_ptr) + k) % NUM_REQ);
      end
   end

   assign grant       = lock ? lock_idx : arb_idx;
   assign m_req_valid = ~rst & (|s_req_valid) & ~fifo_full;
   assign hs          = m_req_valid & m_req_ready;
   assign s_req_ready = hs ? (NUM_REQ'(1) << grant) : '0;
   assign pop         = m_resp_valid & ~fifo_empty;

   always_comb begin
      m_req_addr  = '0;
      m_req_wdata = '0;
      m_req_we    = 1'b0;
      m_req_be    = '0;
      if (m_req_valid) begin
         m_req_addr  = s_req_addr[int'(grant)*ADDR_W +: ADDR_W];
         m_req_wdata = s_req_wdata[int'(grant)*DATA_W +: DATA_W];
         m_req_we    = s_req_we[grant];
         m_req_be    = s_req_be[int'(grant)*BE_W +: BE_W];
      end
   end

   // A stalled offer freezes the grant until the master takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         lock     <= 1'b0;
         lock_idx <= '0;
      end else if (hs) begin
         rr_ptr <= (grant == TAG_BITS'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
         lock   <= 1'b0;
      end else if (m_req_valid) begin
         lock     <= 1'b1;
         lock_idx <= grant;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_resp_valid <= '0;
         s_resp_rdata <= '0;
         err_unexp    <= 1'b0;
      end else begin
         s_resp_valid <= pop ? (NUM_REQ'(1) << head) : '0;
         if (pop) s_resp_rdata <= m_resp_rdata;
         if (m_resp_valid & fifo_empty) err_unexp <= 1'b1;
      end
   end

   arb_tag_fifo #(
      .W     (TAG_BITS),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hs),
      .pop   (m_resp_valid),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (outstanding)
   );

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Randomized and directed bench for axi_req_arbiter with a transaction-level model
// and a response scoreboard drained by an independent monitor.
module tb_axi_req_arbiter;
   import axi_arb_pkg::*;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     s_req_valid = '0;
   logic [NR-1:0]     s_req_ready;
   logic [NR*AW-1:0]  s_req_addr = '0;
   logic [NR*DW-1:0]  s_req_wdata = '0;
   logic [NR-1:0]     s_req_we = '0;
   logic [NR*BW-1:0]  s_req_be = '0;
   logic [NR-1:0]     s_resp_valid;
   logic [DW-1:0]     s_resp_rdata;
   logic              m_req_valid;
   logic              m_req_ready = 1'b0;
   logic [AW-1:0]     m_req_addr;
   logic [DW-1:0]     m_req_wdata;
   logic              m_req_we;
   logic [BW-1:0]     m_req_be;
   logic              m_resp_valid = 1'b0;
   logic [DW-1:0]     m_resp_rdata = '0;
   logic [$clog2(MO):0] outstanding;
   logic              err_unexp;

   axi_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst(rst),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
      .s_req_we(s_req_we), .s_req_be(s_req_be),
      .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
      .m_req_we(m_req_we), .m_req_be(m_req_be),
      .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
      .outstanding(outstanding), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NR-1:0] dst;
      logic [DW-1:0] data;
   } resp_t;

   int    n_cmp = 0;
   int    n_bad = 0;

   // Requester side: each requester holds one pending request until it is accepted.
   req_t  pend [NR];
   bit    act  [NR];

   // Reference model: issuer order queue, rotation start, frozen grant, sticky error.
   int    mdl_q[$];
   int    mdl_rr;
   bit    mdl_lock;
   int    mdl_lock_idx;
   bit    mdl_err;
   resp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic new_req(input int i, input logic [AW-1:0] addr);
      pend[i].addr  = addr;
      pend[i].wdata = $urandom;
      pend[i].we    = 1'($urandom % 2);
      pend[i].be    = BW'($urandom);
      act[i]        = 1'b1;
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NR; i++) begin
         s_req_valid[i]          = act[i];
         s_req_addr[i*AW +: AW]  = pend[i].addr;
         s_req_wdata[i*DW +: DW] = pend[i].wdata;
         s_req_we[i]             = pend[i].we;
         s_req_be[i*BW +: BW]    = pend[i].be;
      end
   endtask

   // One clock cycle: apply inputs, compare combinational/registered outputs, advance the model.
   task automatic step();
      int            g;
      bit            ev;
      logic [NR-1:0] er;
      drive_reqs();
      #1;
      g = -1;
      if (mdl_lock) g = mdl_lock_idx;
      else
         for (int k = 0; k < NR; k++)
            if (g < 0 && act[(mdl_rr + k) % NR]) g = (mdl_rr + k) % NR;
      ev = (g >= 0) && (mdl_q.size() < MO);
      er = '0;
      check("m_req_valid", 64'(m_req_valid), 64'(ev));
      if (ev) begin
         check("m_req_addr", 64'(m_req_addr), 64'(pend[g].addr));
         check("m_req_wdata", 64'(m_req_wdata), 64'(pend[g].wdata));
         check("m_req_we", 64'(m_req_we), 64'(pend[g].we));
         check("m_req_be", 64'(m_req_be), 64'(pend[g].be));
         if (m_req_ready) er[g] = 1'b1;
      end
      check("s_req_ready", 64'(s_req_ready), 64'(er));
      check("outstanding", 64'(outstanding), 64'(mdl_q.size()));
      check("err_unexp", 64'(err_unexp), 64'(mdl_err));
      if (m_resp_valid) begin
         if (mdl_q.size() == 0) mdl_err = 1'b1;
         else exp_q.push_back('{dst: NR'(1) << mdl_q.pop_front(), data: m_resp_rdata});
      end
      if (ev && m_req_ready) begin
         mdl_q.push_back(g);
         mdl_rr   = (g + 1) % NR;
         mdl_lock = 1'b0;
         act[g]   = 1'b0;
      end else if (ev) begin
         mdl_lock     = 1'b1;
         mdl_lock_idx = g;
      end
      @(negedge clk);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      for (int i = 0; i < NR; i++) act[i] = 1'b0;
      s_req_valid  = '1;
      m_req_ready  = 1'b1;
      m_resp_valid = 1'b0;
      rst          = 1'b1;
      mdl_q.delete();
      exp_q.delete();
      mdl_rr = 0; mdl_lock = 1'b0; mdl_err = 1'b0;
      #1;
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err_unexp", 64'(err_unexp), 64'd0);
      check("rst_m_req_valid", 64'(m_req_valid), 64'd0);
      check("rst_m_req_addr", 64'(m_req_addr), 64'd0);
      check("rst_s_req_ready", 64'(s_req_ready), 64'd0);
      check("rst_s_resp_valid", 64'(s_resp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: exactly one response expected per cycle in which the model popped a tag.
   initial begin
      resp_t r;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("s_resp_valid", 64'(s_resp_valid), 64'(r.dst));
            check("s_resp_rdata", 64'(s_resp_rdata), 64'(r.data));
         end else begin
            check("s_resp_idle", 64'(s_resp_valid), 64'd0);
         end
      end
   end

   initial begin
      for (int i = 0; i < NR; i++) begin
         pend[i] = '0;
         act[i]  = 1'b0;
      end
      @(negedge clk);
      do_reset();

      // Single read from requester 0, answered one cycle later.
      pend[0] = '{addr: 32'h1000, wdata: 32'h0, we: 1'b0, be: 4'hF};
      act[0]  = 1'b1;
      m_req_ready = 1'b1;
      step();
      m_resp_valid = 1'b1;
      m_resp_rdata = 32'hDEADBEEF;
      step();
      m_resp_valid = 1'b0;
      step();

      // All requesters busy: grant rotates 0,1,2,3,0,...
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NR; i++) if (!act[i]) new_req(i, $urandom);
         m_resp_valid = (mdl_q.size() > 0);
         m_resp_rdata = $urandom;
         drive_reqs();
         #1;
         check("rr_order", 64'(s_req_ready), 64'(NR'(1) << (k % NR)));
         #1;
         step();
      end
      m_resp_valid = (mdl_q.size() > 0);
      step();
      m_resp_valid = 1'b0;

      // Stall on requester 2 while requester 1 joins: grant stays on 2.
      do_reset();
      m_req_ready = 1'b0;
      new_req(2, 32'h2222_0000);
      for (int k = 0; k < 3; k++) begin
         if (k == 1) new_req(1, 32'h1111_0000);
         step();
      end
      m_req_ready = 1'b1;
      drive_reqs();
      #1;
      check("lock_grant", 64'(s_req_ready), 64'b0100);
      step();
      step();
      check("lock_then_req1", 64'(outstanding), 64'd2);

      // No responses: four accepted, fifth waits for a freed slot.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NR; i++) if (!act[i]) new_req(i, $urandom);
         step();
      end
      check("full_outstanding", 64'(outstanding), 64'd4);
      m_resp_valid = 1'b1;
      m_resp_rdata = 32'h0BAD_F00D;
      step();
      m_resp_valid = 1'b0;
      step();
      check("refill_outstanding", 64'(outstanding), 64'd4);

      // Response with nothing outstanding sets the sticky error.
      do_reset();
      m_resp_valid = 1'b1;
      step();
      m_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) step();
      check("err_sticky", 64'(err_unexp), 64'd1);

      // Reset with three outstanding, then a stale response.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         new_req(k, $urandom);
         step();
      end
      check("pre_rst_outstanding", 64'(outstanding), 64'd3);
      do_reset();
      m_resp_valid = 1'b1;
      step();
      m_resp_valid = 1'b0;
      step();

      // Randomized traffic with random master back-pressure and response timing.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NR; i++) if (!act[i] && ($urandom % 2)) new_req(i, $urandom);
         m_req_ready  = ($urandom % 4) != 0;
         m_resp_valid = (mdl_q.size() > 0) && ($urandom % 2);
         m_resp_rdata = $urandom;
         step();
      end

      // Drain: stop issuing and answer everything, within a bounded number of cycles.
      for (int i = 0; i < NR; i++) act[i] = 1'b0;
      for (int c = 0; c < 50 && mdl_q.size() > 0; c++) begin
         m_resp_valid = 1'b1;
         m_resp_rdata = $urandom;
         step();
      end
      m_resp_valid = 1'b0;
      step();
      step();
      check("drain_outstanding", 64'(outstanding), 64'd0);
      check("drain_scoreboard", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
